pulse_event_queue: RTL and testbench
====================================

PULSE_EVENT_QUEUE -- requirements
Module: pulse_event_queue

Interface
REQ-001 Parameter DEPTH, default 4: event FIFO depth, power of two, 2..16.
REQ-002 Parameter TS_W, default 16: timestamp width in bits.
REQ-003 clk_fast  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 signal_in  input  1  level from the slow-to-fast synchronizer output, already in the clk_fast domain.
REQ-006 evt_valid  output  1  head event present.
REQ-007 evt_ready  input  1  consumer accepts the head event.
REQ-008 evt_rise  output  1  head event type: 1 = rising edge, 0 = falling edge.
REQ-009 evt_ts  output  TS_W  timestamp of the head event.
REQ-010 fill  output  $clog2(DEPTH)+1  number of queued events.
REQ-011 drop_cnt  output  8  count of events lost to a full FIFO.
REQ-012 clr_drop  input  1  single-cycle pulse that clears drop_cnt.

Function
REQ-013 signal_in SHALL be registered into prev_q each cycle; an edge is detected in cycle N when signal_in != prev_q.
REQ-014 A free-running TS_W-bit counter SHALL increment every cycle and wrap from all-ones to 0 without flagging.
REQ-015 On a detected edge, the event {rise = signal_in, ts = counter value in cycle N} SHALL be written in cycle N; evt_valid SHALL assert in cycle N+1 at the earliest; no same-cycle bypass.
REQ-016 The handshake SHALL complete when evt_valid && evt_ready; the head is popped at that edge.
REQ-017 While evt_valid is high and the head is not accepted, evt_rise and evt_ts SHALL stay stable.
REQ-018 FIFO ordering SHALL be strict first-in first-out; pointers SHALL wrap modulo DEPTH.
REQ-019 Push while fill == DEPTH and no pop in the same cycle: the event is discarded, FIFO contents are unchanged, and drop_cnt increments by one, saturating at 255.
REQ-020 Push and pop in the same cycle when full: both happen, fill stays at DEPTH, and nothing is dropped.
REQ-021 Push and pop in the same cycle when not full and not empty: fill is unchanged.
REQ-022 evt_ready while empty SHALL be ignored.
REQ-023 clr_drop SHALL set drop_cnt to 0 at the next edge; if a drop occurs in the same cycle, drop_cnt becomes 1.
REQ-024 fill SHALL equal the write count minus the pop count and is registered.

Reset
REQ-025 While rst is high, at every clk_fast edge: prev_q = 0, the timestamp counter = 0, pointers = 0, fill = 0, evt_valid = 0, evt_rise = 0, evt_ts = 0, drop_cnt = 0.
REQ-026 Reset mid-operation SHALL discard all queued events; FIFO storage need not be cleared.
REQ-027 If signal_in is high in the first cycle after rst deasserts, a rising edge with ts = 0 SHALL be queued.

Configuration
REQ-028 With macro PULSE_EVT_FALL_EN defined, both rising and falling edges are queued.
REQ-029 Without PULSE_EVT_FALL_EN, only rising edges are queued, and evt_rise is tied to 1 whenever evt_valid is high.

Structure
REQ-030 Package pulse_event_pkg SHALL hold the event struct typedef {rise, ts}, the DROP_W = 8 constant and the DROP_MAX = 255 constant.
REQ-031 The FIFO SHALL be a sub-module evt_sync_fifo (storage, pointers, fill, and valid/ready); edge detection, timestamping and drop counting stay in the top module.

Verification
REQ-032 rst high for 2 cycles; signal_in 0 -> 1 at counter = 5, held high -> one event {rise = 1, ts = 5}, evt_valid in the next cycle, fill = 1.
REQ-033 FALL_EN defined; signal_in pulse high for 4 cycles, evt_ready = 1 -> two events in order: {1, t}, then {0, t+4}.
REQ-034 DEPTH = 4, evt_ready = 0, 6 edges -> fill = 4, drop_cnt = 2, head is still the first event; then clr_drop -> drop_cnt = 0.
REQ-035 FIFO full; an edge coincides with evt_ready = 1 -> drop_cnt unchanged, fill = 4, and the new event appears at the tail.
REQ-036 TS_W = 4; edges at counter 14 and at the counter wrap to 2 -> ts values 14 and 2 are delivered in order.
REQ-037 rst asserted while fill = 3 -> evt_valid = 0 and fill = 0 at the next edge; signal_in held high through reset release -> a {1, 0} event is queued.

Source files
------------

// File: rtl/pulse_event_pkg.sv
// pulse_event_pkg
//   Shared types and constants for the pulse event queue.
//   evt_t carries one queued edge event {rise, ts}. The ts field is sized for
//   the widest supported timestamp (TS_W_MAX); narrower builds zero-extend
//   into it, so instances must keep TS_W <= TS_W_MAX.
//   DROP_W / DROP_MAX size and saturate the lost-event counter.
package pulse_event_pkg;

  localparam int DROP_W   = 8;
  localparam int TS_W_MAX = 32;

  localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;

  typedef struct packed {
    logic                rise;
    logic [TS_W_MAX-1:0] ts;
  } evt_t;

endpackage

// File: rtl/pulse_event_queue_fifo.sv
// evt_sync_fifo
//   Single-clock event FIFO with valid/ready on both sides.
//   Handshake: a transfer happens on a rising clk edge exactly when
//   valid && ready are both high in that cycle; ready never depends on the
//   same side's valid, and a producer must not depend on ready to raise valid.
//   in_ready is high when not full, or when full but the head is being popped
//   in the same cycle (simultaneous push/pop keeps fill at DEPTH).
//   The head is read straight from storage and forced to zero while empty, so
//   out_evt is stable for as long as the head is not accepted.
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    write side handshake, in_evt = event to store
//   out_valid/out_ready  read side handshake, out_evt = head event
//   fill                 registered number of stored events
// Parameters
//   DEPTH                power of two, 2..16; pointers wrap modulo DEPTH
module evt_sync_fifo
  import pulse_event_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  evt_t                   in_evt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output evt_t                   out_evt,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_FILL = (AW + 1)'(DEPTH);

  evt_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_fire;
  logic          pop_fire;

  assign out_valid = (fill != '0);
  assign pop_fire  = out_valid && out_ready;
  assign in_ready  = (fill != FULL_FILL) || pop_fire;
  assign push_fire = in_valid && in_ready;
  assign out_evt   = out_valid ? mem[rd_ptr] : '0;

  // Storage is intentionally not reset; fill gates what is visible.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[wr_ptr] <= in_evt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_fire, pop_fire})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: rtl/pulse_event_queue.sv
// pulse_event_queue
//   Detects edges on an already-synchronized level, timestamps them with a
//   free-running wrapping counter and queues {rise, ts} events in a FIFO.
//   Events arriving while the FIFO is full (and not popping) are dropped and
//   counted in a saturating drop counter.
//   An edge seen in cycle N is written in cycle N; evt_valid rises in N+1.
// Build option
//   PULSE_EVT_FALL_EN  defined: rising and falling edges are queued.
//                      undefined (default): only rising edges are queued and
//                      evt_rise reads 1 whenever evt_valid is high.
// Ports
//   clk_fast   clock; rst synchronous active-high reset
//   signal_in  level in the clk_fast domain
//   evt_valid / evt_ready   head event handshake (transfer on valid && ready)
//   evt_rise, evt_ts        head event type and timestamp
//   fill       number of queued events
//   drop_cnt   events lost to a full FIFO, saturating; clr_drop clears it
module pulse_event_queue
  import pulse_event_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TS_W  = 16
) (
  input  logic                   clk_fast,
  input  logic                   rst,
  input  logic                   signal_in,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic                   evt_rise,
  output logic [TS_W-1:0]        evt_ts,
  output logic [$clog2(DEPTH):0] fill,
  output logic [DROP_W-1:0]      drop_cnt,
  input  logic                   clr_drop
);

  logic            prev_q;
  logic [TS_W-1:0] ts_cnt;
  logic            edge_det;
  logic            push_req;
  logic            push_ready;
  logic            drop;
  evt_t            push_evt;
  evt_t            head_evt;

  assign edge_det = signal_in ^ prev_q;

`ifdef PULSE_EVT_FALL_EN
  assign push_req = edge_det;
`else
  assign push_req = edge_det && signal_in;
`endif

  assign push_evt = '{rise: signal_in, ts: TS_W_MAX'(ts_cnt)};
  assign drop     = push_req && !push_ready;

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      prev_q <= 1'b0;
      ts_cnt <= '0;
    end else begin
      prev_q <= signal_in;
      ts_cnt <= ts_cnt + 1'b1;
    end
  end

  // Clear wins over accumulation, but a drop in the clearing cycle still
  // counts as the first event of the new window.
  always_ff @(posedge clk_fast) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (clr_drop) begin
      drop_cnt <= drop ? DROP_W'(1) : '0;
    end else if (drop && (drop_cnt != DROP_MAX)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  evt_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk_fast),
    .rst       (rst),
    .in_valid  (push_req),
    .in_ready  (push_ready),
    .in_evt    (push_evt),
    .out_valid (evt_valid),
    .out_ready (evt_ready),
    .out_evt   (head_evt),
    .fill      (fill)
  );

  assign evt_ts = head_evt.ts[TS_W-1:0];

`ifdef PULSE_EVT_FALL_EN
  assign evt_rise = head_evt.rise;

  // Stored timestamps are zero-extended, so the unused high bits stay zero.
  always_ff @(posedge clk_fast) begin
    if (!rst && evt_valid) begin
      assert ((head_evt.ts >> TS_W) == '0);
    end
  end
`else
  assign evt_rise = evt_valid;

  // Only rising edges are stored, and timestamps are zero-extended.
  always_ff @(posedge clk_fast) begin
    if (!rst && evt_valid) begin
      assert (head_evt.rise && ((head_evt.ts >> TS_W) == '0));
    end
  end
`endif

endmodule

// File: tb/tb_pulse_event_queue.sv
// tb_pulse_event_queue
//   Self-checking bench for pulse_event_queue (DEPTH = 4, TS_W = 4).
//   A small reference model tracks prev level, timestamp counter, queued
//   events (exp_q) and drop count; popped heads are compared against exp_q.
//   A vector table covers the full/drop/clear sequence; hand-written steps
//   cover reset, first-event latency, pulse ordering, full push+pop,
//   timestamp wrap and reset mid-operation. Works with or without
//   PULSE_EVT_FALL_EN.
module tb_pulse_event_queue;

  localparam int DEPTH = 4;
  localparam int TS_W  = 4;
  localparam int FW    = 3;

  logic            clk_fast  = 1'b0;
  logic            rst       = 1'b1;
  logic            signal_in = 1'b0;
  logic            evt_ready = 1'b0;
  logic            clr_drop  = 1'b0;
  logic            evt_valid;
  logic            evt_rise;
  logic [TS_W-1:0] evt_ts;
  logic [FW-1:0]   fill;
  logic [7:0]      drop_cnt;

  pulse_event_queue #(
    .DEPTH (DEPTH),
    .TS_W  (TS_W)
  ) dut (
    .clk_fast  (clk_fast),
    .rst       (rst),
    .signal_in (signal_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_rise  (evt_rise),
    .evt_ts    (evt_ts),
    .fill      (fill),
    .drop_cnt  (drop_cnt),
    .clr_drop  (clr_drop)
  );

  // clock / reset
  always #5 clk_fast = ~clk_fast;

  // scoreboard state
  int              n_tests = 0;
  int              n_fail  = 0;
  logic [TS_W:0]   exp_q[$];
  logic            m_prev  = 1'b0;
  logic [TS_W-1:0] m_cnt   = '0;
  int              m_drop  = 0;

  typedef struct {
    logic sig;
    logic rdy;
    logic clr;
    int   fill;
    int   drop;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic sig, input logic rdy, input logic clr,
                                  input int f, input int d);
    vec_t v;
    v.sig = sig; v.rdy = rdy; v.clr = clr; v.fill = f; v.drop = d;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, compare any popped head,
  // then return #1 after the clock edge.
  task automatic step(input logic sig, input logic rdy, input logic clr, input logic r);
    logic edge_s, push, pop, full, drop;
    signal_in = sig;
    evt_ready = rdy;
    clr_drop  = clr;
    rst       = r;
    #1;
    if (r) begin
      exp_q.delete();
      m_prev = 1'b0;
      m_cnt  = '0;
      m_drop = 0;
    end else begin
      edge_s = (sig != m_prev);
`ifdef PULSE_EVT_FALL_EN
      push = edge_s;
`else
      push = edge_s && sig;
`endif
      pop  = rdy && (exp_q.size() > 0);
      full = (exp_q.size() == DEPTH);
      drop = push && full && !pop;
      if (pop) begin
        chk("pop_head", {evt_valid, evt_rise, evt_ts}, {1'b1, exp_q[0]});
        void'(exp_q.pop_front());
      end
      if (push && !drop) exp_q.push_back({sig, m_cnt});
      if (clr) m_drop = drop ? 1 : 0;
      else if (drop && m_drop < 255) m_drop++;
      m_prev = sig;
      m_cnt  = m_cnt + 1'b1;
    end
    @(posedge clk_fast);
    #1;
  endtask

  task automatic check_state(input string name);
    chk({name, "_fill"}, 32'(fill), 32'(exp_q.size()));
    chk({name, "_valid"}, 32'(evt_valid), 32'(exp_q.size() > 0));
    chk({name, "_drop"}, 32'(drop_cnt), 32'(m_drop));
    if (exp_q.size() > 0) chk({name, "_head"}, {evt_rise, evt_ts}, exp_q[0]);
  endtask

  initial begin
    logic s;
    int   guard;

    // reset state
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_fill", 32'(fill), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_rise", 32'(evt_rise), 0);
    chk("rst_ts", 32'(evt_ts), 0);

    // first event: rise at counter 5, valid only in the next cycle
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    signal_in = 1'b1;
    #1;
    chk("no_bypass_valid", 32'(evt_valid), 0);
    step(1, 0, 0, 0);
    chk("e1_valid", 32'(evt_valid), 1);
    chk("e1_fill", 32'(fill), 1);
    chk("e1_rise", 32'(evt_rise), 1);
    chk("e1_ts", 32'(evt_ts), 5);
    check_state("e1");

    // 4-cycle pulse with ready high: {1,5} then (fall build) {0,9}
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    step(0, 1, 0, 0);
`ifdef PULSE_EVT_FALL_EN
    chk("fall_valid", 32'(evt_valid), 1);
    chk("fall_rise", 32'(evt_rise), 0);
    chk("fall_ts", 32'(evt_ts), 9);
`else
    chk("nofall_valid", 32'(evt_valid), 0);
`endif
    step(0, 1, 0, 0);
    check_state("pulse_done");

    // six edges into a depth-4 FIFO with ready low, then clear drops
`ifdef PULSE_EVT_FALL_EN
    add_vec(1, 0, 0, 1, 0); add_vec(0, 0, 0, 2, 0); add_vec(1, 0, 0, 3, 0);
    add_vec(0, 0, 0, 4, 0); add_vec(1, 0, 0, 4, 1); add_vec(0, 0, 0, 4, 2);
    add_vec(0, 0, 1, 4, 0);
`else
    add_vec(1, 0, 0, 1, 0); add_vec(0, 0, 0, 1, 0); add_vec(1, 0, 0, 2, 0);
    add_vec(0, 0, 0, 2, 0); add_vec(1, 0, 0, 3, 0); add_vec(0, 0, 0, 3, 0);
    add_vec(1, 0, 0, 4, 0); add_vec(0, 0, 0, 4, 0); add_vec(1, 0, 0, 4, 1);
    add_vec(0, 0, 0, 4, 1); add_vec(1, 0, 0, 4, 2); add_vec(0, 0, 0, 4, 2);
    add_vec(0, 0, 1, 4, 0);
`endif
    foreach (vecs[i]) begin
      step(vecs[i].sig, vecs[i].rdy, vecs[i].clr, 0);
      chk("vec_fill", 32'(fill), 32'(vecs[i].fill));
      chk("vec_drop", 32'(drop_cnt), 32'(vecs[i].drop));
      check_state("vec");
    end

    // full FIFO: edge coincides with a pop, nothing dropped, new tail kept
    step(1, 1, 0, 0);
    chk("full_pp_fill", 32'(fill), 4);
    chk("full_pp_drop", 32'(drop_cnt), 0);
    check_state("full_pp");
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    chk("drained_valid", 32'(evt_valid), 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    check_state("pre_wrap");

    // timestamp wrap: edges at counter 14 and 2
    guard = 0;
    while (m_cnt != 4'd14 && guard < 20) begin
      step(0, 0, 0, 0);
      guard++;
    end
    chk("wrap_align", 32'(m_cnt), 14);
    step(1, 0, 0, 0);
`ifdef PULSE_EVT_FALL_EN
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 0, 0, 0);
`else
    step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(1, 0, 0, 0);
`endif
    chk("wrap_fill", 32'(fill), 2);
    chk("wrap_h0_ts", 32'(evt_ts), 14);
    step(signal_in, 1, 0, 0);
    chk("wrap_h1_ts", 32'(evt_ts), 2);
    step(signal_in, 1, 0, 0);
    chk("wrap_empty", 32'(evt_valid), 0);

    // reset mid-operation with three events queued, signal held high
    s = signal_in;
    guard = 0;
    while (exp_q.size() < 3 && guard < 10) begin
      s = ~s;
      step(s, 0, 0, 0);
      guard++;
    end
    chk("pre_rst_fill", 32'(fill), 3);
    step(1, 0, 0, 1);
    chk("mid_rst_valid", 32'(evt_valid), 0);
    chk("mid_rst_fill", 32'(fill), 0);
    step(1, 0, 0, 0);
    chk("post_rst_valid", 32'(evt_valid), 1);
    chk("post_rst_fill", 32'(fill), 1);
    chk("post_rst_rise", 32'(evt_rise), 1);
    chk("post_rst_ts", 32'(evt_ts), 0);

    // random traffic against the model
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 15) == 0), 0);
      check_state("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
